ub_act_skew_reader: RTL and testbench
=====================================

Name: ub_act_skew_reader

Overview:
- Read side of the unified-buffer SRAM: the host/testbench writes activation rows into the SRAM, and this block reads them back out.
- On start, it reads a run of consecutive SRAM words (one activation row per word) and splits each word into NUM_PE_ROWS byte lanes.
- It applies the diagonal skew the systolic array needs (lane k delayed k cycles) and drives the array's activation inputs with per-lane valids.
- It signals busy/done so the TPU controller can sequence weight load and compute.

Parameters:
ADDRESSSIZE, 10, SRAM address width
WORDSIZE, 64, SRAM word width; must equal DATA_BW*NUM_PE_ROWS
DATA_BW, 8, activation element width per lane
NUM_PE_ROWS, 8, number of array rows / lanes per word

Ports:
clk  in  1  clock; all logic on rising edge
rstn  in  1  synchronous reset, active-high (1 = reset)
start  in  1  one-cycle request; sampled only in IDLE
base_addr  in  ADDRESSSIZE  first SRAM address; latched on accepted start
num_rows  in  ADDRESSSIZE  number of words to read; latched on accepted start
sram_read_en  out  1  SRAM read strobe
sram_address  out  ADDRESSSIZE  SRAM read address
sram_data_out  in  WORDSIZE  SRAM read data, valid the cycle after the address
act_out  out  WORDSIZE  skewed activations; lane k = bits [k*DATA_BW +: DATA_BW]
act_valid  out  NUM_PE_ROWS  per-lane valid
busy  out  1  high from first read cycle until last lane output
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rstn=1 at an edge): FSM to IDLE. All outputs 0 on the next cycle, including sram_address, act_out, act_valid, busy, done. All skew stages cleared. Reset mid-operation aborts the run with no done pulse.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE, start=1: latch base_addr and num_rows.
  - num_rows=0: go to DONE. done=1 in the following cycle; no reads issued.
  - Otherwise: go to READ.
- Cycle numbering: the start edge is cycle 0. READ occupies cycles 1..num_rows.
  - sram_read_en=1 in each READ cycle.
  - sram_address = base + i in cycle i+1.
  - Address addition is modulo 2^ADDRESSSIZE, so the address wraps from 1023 to 0.
- Word i arrives on sram_data_out in cycle i+2. It is captured and then skewed.
- Lane k of row i appears on act_out with act_valid[k]=1 in cycle i+3+k.
- Lanes with act_valid=0 drive 0 on act_out (required: the array sums zeros harmlessly).
- After the last READ cycle, sram_read_en=0 and sram_address holds its last value. FSM enters DRAIN for NUM_PE_ROWS+1 cycles, counted by an internal counter.
- DONE lasts one cycle (cycle num_rows+NUM_PE_ROWS+2): done=1, busy=0. Then IDLE.
- busy=1 exactly in cycles 1..num_rows+NUM_PE_ROWS+1.
- start while not IDLE is ignored; it is neither queued nor restarts the run.
- start in the same cycle DONE is asserted is ignored. A new start is accepted from the next IDLE cycle.
- The skew pipeline is a per-lane shift chain: lane k has k registers after the capture stage. Data and valid shift together every cycle unconditionally.

Test Plan:
- Reset then idle: rstn=1 for 2 cycles, then 0 -> all outputs 0; busy=0; no sram_read_en for 10 cycles.
- Basic run: SRAM[i] = word with byte k = 8'h10*i+k, for i=0..7. start with base=0, num_rows=8 ->
  - sram_address 0..7 in cycles 1..8;
  - lane 3 shows 8'h03 at cycle 6 and 8'h73 at cycle 13;
  - lane 7 last valid at cycle 17;
  - done=1 only in cycle 18; busy=1 in cycles 1..17.
- Wrap: base=1022, num_rows=4 -> addresses 1022, 1023, 0, 1; data from those words emerges skewed in the same order; done at cycle 14.
- Zero length: num_rows=0 -> no sram_read_en; done=1 in cycle 1; busy never asserted.
- Start during busy: second start at cycle 5 of an 8-row run -> ignored; exactly one done at cycle 18. A start at cycle 19 begins a new run normally.
- Reset mid-run: rstn=1 at cycle 6 of an 8-row run -> next cycle all outputs 0, act_valid=0, no done pulse. A later start runs cleanly.

Source files
------------

// File: rtl/ub_act_skew_reader_if.sv
// Unified-buffer activation reader bus: start/config, SRAM read port and
// skewed activation outputs toward the systolic array.
interface ub_act_skew_reader_if #(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 64,
  parameter int NUM_PE_ROWS = 8
);
  logic                   start;
  logic [ADDRESSSIZE-1:0] base_addr;
  logic [ADDRESSSIZE-1:0] num_rows;
  logic                   sram_read_en;
  logic [ADDRESSSIZE-1:0] sram_address;
  logic [WORDSIZE-1:0]    sram_data_out;
  logic [WORDSIZE-1:0]    act_out;
  logic [NUM_PE_ROWS-1:0] act_valid;
  logic                   busy;
  logic                   done;

  modport slave (
    input  start, base_addr, num_rows, sram_data_out,
    output sram_read_en, sram_address, act_out, act_valid, busy, done
  );

  modport master (
    output start, base_addr, num_rows, sram_data_out,
    input  sram_read_en, sram_address, act_out, act_valid, busy, done
  );
endinterface

// File: rtl/ub_act_skew_reader.sv
// Reads a run of unified-buffer words and feeds them to the systolic array
// with a diagonal skew (lane k delayed k cycles) and per-lane valids.
//
// state   | meaning
// S_IDLE  | waiting for start; latches base address and row count
// S_READ  | one SRAM read per cycle, cnt_q counts rows left
// S_DRAIN | NUM_PE_ROWS+1 cycles letting the skew pipeline empty
// S_DONE  | one-cycle done pulse, start ignored
module ub_act_skew_reader #(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 64,
  parameter int DATA_BW     = 8,
  parameter int NUM_PE_ROWS = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  ub_act_skew_reader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDRESSSIZE-1:0] DRAIN_LOAD = ADDRESSSIZE'(NUM_PE_ROWS);
  localparam logic [ADDRESSSIZE-1:0] CNT_ONE    = ADDRESSSIZE'(1);

  state_t                 state_q;
  state_t                 state_nxt;
  logic [ADDRESSSIZE-1:0] addr_q;
  logic [ADDRESSSIZE-1:0] cnt_q;
  logic                   rd_pending_q;
  logic [WORDSIZE-1:0]    act_w;
  logic [NUM_PE_ROWS-1:0] valid_w;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.num_rows == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == CNT_ONE) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // cnt_q is reused: rows left while reading, then drain cycles left.
  always_ff @(posedge clk) begin
    if (rstn) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= (state_q == S_READ);
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            addr_q <= bus.base_addr;
            cnt_q  <= bus.num_rows;
          end
        end
        S_READ: begin
          if (cnt_q == CNT_ONE) begin
            cnt_q <= DRAIN_LOAD;
          end else begin
            cnt_q  <= cnt_q - CNT_ONE;
            addr_q <= addr_q + CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Capture stage plus k shift registers per lane; invalid slots carry zero.
  for (genvar k = 0; k < NUM_PE_ROWS; k++) begin : g_lane
    logic [k:0][DATA_BW-1:0] sr_d;
    logic [k:0]              sr_v;

    always_ff @(posedge clk) begin
      if (rstn) begin
        sr_d <= '0;
        sr_v <= '0;
      end else begin
        sr_d[0] <= rd_pending_q ? bus.sram_data_out[k*DATA_BW +: DATA_BW] : '0;
        sr_v[0] <= rd_pending_q;
        for (int s = 1; s <= k; s++) begin
          sr_d[s] <= sr_d[s-1];
          sr_v[s] <= sr_v[s-1];
        end
      end
    end

    assign act_w[k*DATA_BW +: DATA_BW] = sr_d[k];
    assign valid_w[k]                  = sr_v[k];
  end

  assign bus.act_out      = act_w;
  assign bus.act_valid    = valid_w;
  assign bus.sram_read_en = (state_q == S_READ);
  assign bus.sram_address = addr_q;
  assign bus.busy         = (state_q == S_READ) || (state_q == S_DRAIN);
  assign bus.done         = (state_q == S_DONE);

endmodule

// File: tb/tb_ub_act_skew_reader.sv
// Directed bench for ub_act_skew_reader: SRAM model, per-cycle expectations
// derived from the cycle timing of a run, reset and start-ignore cases.
module tb_ub_act_skew_reader;
  localparam int AW  = 10;
  localparam int WW  = 64;
  localparam int DBW = 8;
  localparam int NPR = 8;

  logic clk = 1'b0;
  logic rstn;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cur_c  = 0;

  logic [WW-1:0] mem [1024];
  logic [WW-1:0] sram_q = '0;

  ub_act_skew_reader_if #(.ADDRESSSIZE(AW), .WORDSIZE(WW), .NUM_PE_ROWS(NPR)) bus ();

  ub_act_skew_reader #(
    .ADDRESSSIZE(AW),
    .WORDSIZE   (WW),
    .DATA_BW    (DBW),
    .NUM_PE_ROWS(NPR)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sram_read_en) sram_q <= mem[bus.sram_address];
  end
  assign bus.sram_data_out = sram_q;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cur_c);
    end
  endtask

  // Start a run in the current cycle (cycle 0) and check every cycle through
  // one cycle past done. extra_start >= 0 also pulses start at that cycle and
  // in the done cycle; rst_at >= 0 asserts reset in that cycle.
  task automatic run(input logic [AW-1:0] base, input int n, input int extra_start,
                     input int rst_at);
    int              done_c;
    int              done_cnt;
    int              i;
    logic            aborted;
    logic [WW-1:0]   exp_act;
    logic [NPR-1:0]  exp_v;
    logic [WW-1:0]   w;
    logic [AW-1:0]   exp_addr;
    done_c   = (n == 0) ? 1 : n + NPR + 2;
    done_cnt = 0;
    aborted  = 1'b0;
    bus.base_addr = base;
    bus.num_rows  = AW'(n);
    bus.start     = 1'b1;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      rstn      = 1'b0;
      cur_c     = c;
      aborted   = (rst_at >= 0) && (c > rst_at);
      exp_act   = '0;
      exp_v     = '0;
      if (!aborted) begin
        for (int k = 0; k < NPR; k++) begin
          i = c - 3 - k;
          if (i >= 0 && i < n) begin
            w = mem[AW'(base + AW'(i))];
            exp_v[k] = 1'b1;
            exp_act[k*DBW +: DBW] = w[k*DBW +: DBW];
          end
        end
      end
      chk("read_en", bus.sram_read_en, !aborted && c <= n);
      if (aborted) begin
        chk("addr_rst", bus.sram_address, '0);
      end else if (n > 0) begin
        exp_addr = (c <= n) ? AW'(base + AW'(c - 1)) : AW'(base + AW'(n - 1));
        chk("addr", bus.sram_address, exp_addr);
      end
      chk("act_out", bus.act_out, exp_act);
      chk("act_valid", bus.act_valid, exp_v);
      chk("busy", bus.busy, !aborted && n > 0 && c <= n + NPR + 1);
      chk("done", bus.done, !aborted && c == done_c);
      if (bus.done) done_cnt++;
      if (extra_start >= 0 && (c == extra_start || c == done_c)) bus.start = 1'b1;
      if (c == rst_at) rstn = 1'b1;
    end
    chk("done_count", done_cnt, (rst_at >= 0) ? 0 : 1);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NPR; k++) mem[r][k*DBW +: DBW] = 8'(8'h10 * r + k);
    end
    for (int k = 0; k < NPR; k++) begin
      mem[1022][k*DBW +: DBW] = 8'(8'hA0 + k);
      mem[1023][k*DBW +: DBW] = 8'(8'hB0 + k);
    end

    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_rows  = '0;
    rstn          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cur_c = c;
      chk("idle_read_en", bus.sram_read_en, '0);
      chk("idle_busy", bus.busy, '0);
      chk("idle_done", bus.done, '0);
      chk("idle_valid", bus.act_valid, '0);
      chk("idle_act", bus.act_out, '0);
      chk("idle_addr", bus.sram_address, '0);
      @(posedge clk);
      #1;
    end

    run(10'd0, 8, -1, -1);
    run(10'd0, 8, 5, -1);
    run(10'd0, 8, -1, -1);
    run(10'd1022, 4, -1, -1);
    run(10'd0, 0, -1, -1);
    run(10'd0, 8, -1, 6);
    run(10'd3, 5, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
